pdm_cic_decimator: RTL and testbench

- Front end of the mic-array chain, directly upstream of the delay-and-sum beamformer.
- Generates the shared PDM clock and samples NUM_MICS 1-bit PDM lines.
- Converts each line to signed BIT_WIDTH-bit PCM with an order-ORDER CIC decimator (rate DEC).
- Publishes all mics' samples atomically with a one-cycle valid strobe. This feeds the beamformer's per-mic PCM inputs.

---
 rtl/mic_array_pkg.sv | 25 ++
 rtl/cic_integrator.sv | 45 ++++
 rtl/pdm_cic_decimator.sv | 204 ++++++++++++++++++++
 tb/tb_pdm_cic_decimator.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mic_array_pkg.sv
// rtl/mic_array_pkg.sv - shared constants, types and helpers for the mic-array front end
package mic_array_pkg;

    localparam int NUM_MICS  = 9;
    localparam int BIT_WIDTH = 8;

    typedef logic signed [BIT_WIDTH-1:0] pcm_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMB,
        ST_PUBLISH
    } comb_state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// rtl/cic_integrator.sv - ORDER-stage wrapping CIC integrator chain for one PDM line
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of all stages
//   strobe     : PDM sample strobe, one cycle per PDM bit
//   pdm_bit    : PDM input bit, 1 -> +1, 0 -> -1
//   acc        : last integrator stage
module cic_integrator #(
    parameter int ORDER = 3,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    strobe,
    input  logic                    pdm_bit,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] integ [ORDER];
    logic signed [ACC_W-1:0] step;

    assign step = pdm_bit ? ACC_W'(1) : '1;

    // Each stage adds the previous stage's pre-update value; sums wrap freely,
    // the comb section undoes the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < ORDER; j++) begin
                integ[j] <= '0;
            end
        end else if (clr) begin
            for (int j = 0; j < ORDER; j++) begin
                integ[j] <= '0;
            end
        end else if (strobe) begin
            integ[0] <= integ[0] + step;
            for (int j = 1; j < ORDER; j++) begin
                integ[j] <= integ[j] + integ[j-1];
            end
        end
    end

    assign acc = integ[ORDER-1];

endmodule

// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - PDM clock generation and multi-mic CIC decimation to PCM
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : run enable; low clears the pipeline and forces pdm_clk/pcm_valid low
//   pdm_data_in  : PDM bits, bit k = mic k
//   pdm_clk      : PDM clock to the microphones
//   pcm_data_out : mic k at [k*BIT_WIDTH +: BIT_WIDTH], signed
//   pcm_valid    : one-cycle strobe in the cycle pcm_data_out takes a new frame
module pdm_cic_decimator #(
    parameter int NUM_MICS  = mic_array_pkg::NUM_MICS,
    parameter int BIT_WIDTH = mic_array_pkg::BIT_WIDTH,
    parameter int CLK_DIV   = 16,
    parameter int DEC       = 64,
    parameter int ORDER     = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [NUM_MICS-1:0]           pdm_data_in,
    output logic                          pdm_clk,
    output logic [NUM_MICS*BIT_WIDTH-1:0] pcm_data_out,
    output logic                          pcm_valid
);
    import mic_array_pkg::*;

    localparam int LOG2_DEC = clog2(DEC);
    localparam int ACC_W    = ORDER * LOG2_DEC + 2;
    localparam int SHIFT    = ORDER * LOG2_DEC + 1 - BIT_WIDTH;
    localparam int DIV_W    = clog2(CLK_DIV);
    localparam int MIC_W    = clog2(NUM_MICS + 1);
    localparam int WARM_W   = clog2(ORDER + 1);

    localparam logic [DIV_W-1:0]        DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]        DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [LOG2_DEC-1:0]     DEC_LAST  = LOG2_DEC'(DEC - 1);
    localparam logic [MIC_W-1:0]        MIC_LAST  = MIC_W'(NUM_MICS - 1);
    localparam logic [WARM_W-1:0]       WARM_DONE = WARM_W'(ORDER);
    localparam logic signed [ACC_W-1:0] PCM_MAX   = ACC_W'((1 << (BIT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] PCM_MIN   = ~PCM_MAX;

    // ---------------- divider and decimation counter ----------------
    logic [DIV_W-1:0]    div_cnt;
    logic [DIV_W-1:0]    div_nxt;
    logic [LOG2_DEC-1:0] dec_cnt;
    logic                pdm_clk_q;
    logic                strobe;
    logic                frame_strobe;

    assign strobe       = en && (div_cnt == DIV_LAST);
    assign frame_strobe = strobe && (dec_cnt == DEC_LAST);
    assign div_nxt      = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

    // pdm_clk_q tracks div_nxt so the registered clock lines up with div_cnt:
    // the strobe cycle (div_cnt at its last count) is the last high cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            dec_cnt   <= '0;
            pdm_clk_q <= 1'b0;
        end else if (!en) begin
            div_cnt   <= '0;
            dec_cnt   <= '0;
            pdm_clk_q <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            pdm_clk_q <= (div_nxt >= DIV_HALF);
            if (strobe) begin
                dec_cnt <= dec_cnt + 1'b1;
            end
        end
    end

    assign pdm_clk = pdm_clk_q && en;

    // ---------------- per-mic integrators ----------------
    logic signed [ACC_W-1:0] integ_out [NUM_MICS];

    for (genvar k = 0; k < NUM_MICS; k++) begin : gen_mic
        cic_integrator #(
            .ORDER (ORDER),
            .ACC_W (ACC_W)
        ) u_integ (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (!en),
            .strobe  (strobe),
            .pdm_bit (pdm_data_in[k]),
            .acc     (integ_out[k])
        );
    end

    // ---------------- comb engine FSM ----------------
    comb_state_t      state_q;
    comb_state_t      state_d;
    logic [MIC_W-1:0] mic_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (!en) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (frame_strobe) state_d = ST_COMB;
            ST_COMB:    if (mic_idx == MIC_LAST) state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ---------------- comb datapath (one mic per cycle) ----------------
    logic signed [ACC_W-1:0]     snap    [NUM_MICS];
    logic signed [ACC_W-1:0]     hist    [NUM_MICS][ORDER];
    logic signed [BIT_WIDTH-1:0] staged  [NUM_MICS];
    logic signed [ACC_W-1:0]     comb_in [ORDER];
    logic signed [ACC_W-1:0]     comb_out;
    logic [WARM_W-1:0]           warm_cnt;
    logic                        frame_pub;
    logic                        publish;
    logic [NUM_MICS*BIT_WIDTH-1:0] staged_flat;
    logic [NUM_MICS*BIT_WIDTH-1:0] out_q;

    function automatic logic signed [BIT_WIDTH-1:0] scale_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> SHIFT;
        if (s > PCM_MAX) return PCM_MAX[BIT_WIDTH-1:0];
        if (s < PCM_MIN) return PCM_MIN[BIT_WIDTH-1:0];
        return s[BIT_WIDTH-1:0];
    endfunction

    // All ORDER comb stages of the selected mic in one combinational chain.
    always_comb begin
        comb_out = snap[mic_idx];
        for (int s = 0; s < ORDER; s++) begin
            comb_in[s] = comb_out;
            comb_out   = comb_out - hist[mic_idx][s];
        end
    end

    always_comb begin
        staged_flat = '0;
        for (int k = 0; k < NUM_MICS; k++) begin
            staged_flat[k*BIT_WIDTH +: BIT_WIDTH] = staged[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_MICS; k++) begin
                snap[k]   <= '0;
                staged[k] <= '0;
                for (int s = 0; s < ORDER; s++) begin
                    hist[k][s] <= '0;
                end
            end
            mic_idx   <= '0;
            warm_cnt  <= '0;
            frame_pub <= 1'b0;
            out_q     <= '0;
        end else if (!en) begin
            for (int k = 0; k < NUM_MICS; k++) begin
                for (int s = 0; s < ORDER; s++) begin
                    hist[k][s] <= '0;
                end
            end
            mic_idx   <= '0;
            warm_cnt  <= '0;
            frame_pub <= 1'b0;
        end else begin
            if (frame_strobe) begin
                for (int k = 0; k < NUM_MICS; k++) begin
                    snap[k] <= integ_out[k];
                end
                mic_idx   <= '0;
                // Comb history only becomes meaningful after ORDER frames.
                frame_pub <= (warm_cnt == WARM_DONE);
                if (warm_cnt != WARM_DONE) begin
                    warm_cnt <= warm_cnt + 1'b1;
                end
            end
            if (state_q == ST_COMB) begin
                for (int s = 0; s < ORDER; s++) begin
                    hist[mic_idx][s] <= comb_in[s];
                end
                staged[mic_idx] <= scale_sat(comb_out);
                mic_idx         <= mic_idx + 1'b1;
            end
            if (publish) begin
                out_q <= staged_flat;
            end
        end
    end

    // New frame is visible during the PUBLISH cycle itself, in step with pcm_valid.
    assign publish      = en && (state_q == ST_PUBLISH) && frame_pub;
    assign pcm_valid    = publish;
    assign pcm_data_out = publish ? staged_flat : out_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb/tb_pdm_cic_decimator.sv - table-driven bench for pdm_cic_decimator
module tb_pdm_cic_decimator;

    localparam int NM          = 9;
    localparam int BW          = 8;
    localparam int FIRST_VALID = 4105;
    localparam int FRAME       = 1024;
    localparam int BUDGET      = 6000;
    localparam logic [NM*BW-1:0] ALL_7F = {NM{8'h7F}};
    localparam logic [NM*BW-1:0] ALL_80 = {NM{8'h80}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NM-1:0]     pdm_data_in;
    logic              pdm_clk;
    logic [NM*BW-1:0]  pcm_data_out;
    logic              pcm_valid;

    logic [NM-1:0]     ones_mask = '0;
    logic [NM-1:0]     alt_mask  = '0;
    logic              alt_bit   = 1'b0;
    int                cyc       = 0;
    int                n_chk     = 0;
    int                n_fail    = 0;

    typedef struct {
        logic [NM-1:0]    ones;
        logic [NM-1:0]    alt;
        logic [NM*BW-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    pdm_cic_decimator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pdm_data_in  (pdm_data_in),
        .pdm_clk      (pdm_clk),
        .pcm_data_out (pcm_data_out),
        .pcm_valid    (pcm_valid)
    );

    always #5 clk = ~clk;

    // One toggle per PDM period, so each sample strobe sees the opposite bit.
    always @(posedge pdm_clk) alt_bit <= ~alt_bit;

    assign pdm_data_in = (ones_mask & ~alt_mask) | (alt_mask & {NM{alt_bit}});

    // Cycle index since the last enable/reset release; cycle 0 is the first enabled cycle.
    always @(posedge clk) begin
        if (!rst_n || !en) cyc <= 0;
        else               cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [NM*BW-1:0] act, input logic [NM*BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic restart(input logic [NM-1:0] ones, input logic [NM-1:0] alt);
        @(negedge clk);
        en        = 1'b0;
        ones_mask = ones;
        alt_mask  = alt;
        @(negedge clk);
        en = 1'b1;
    endtask

    task automatic wait_valid(output int at);
        at = -1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (pcm_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int  at;
        int  held_ok;

        vecs[0] = '{ones: 9'h1FF, alt: 9'h000, exp: ALL_7F};
        vecs[1] = '{ones: 9'h000, alt: 9'h000, exp: ALL_80};
        vecs[2] = '{ones: 9'h1FF, alt: 9'h001, exp: {{8{8'h7F}}, 8'h00}};
        vecs[3] = '{ones: 9'h1FF, alt: 9'h010, exp: {{4{8'h7F}}, 8'h00, {4{8'h7F}}}};
        vecs[4] = '{ones: 9'h1FF, alt: 9'h100, exp: {8'h00, {8{8'h7F}}}};
        vecs[5] = '{ones: 9'h155, alt: 9'h000,
                    exp: {8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F}};

        // Power-on reset state
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pdm_clk", {71'd0, pdm_clk}, '0);
        chk("reset_valid", {71'd0, pcm_valid}, '0);
        chk("reset_data", pcm_data_out, '0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            restart(vecs[v].ones, vecs[v].alt);
            if (v == 0) begin
                for (int i = 0; i < 32; i++) begin
                    @(negedge clk);
                    chk_i($sformatf("pdm_clk_cyc%0d", cyc), int'(pdm_clk), int'((cyc % 16) >= 8));
                end
            end
            wait_valid(at);
            chk_i($sformatf("v%0d_first_latency", v), at, FIRST_VALID);
            chk($sformatf("v%0d_first_data", v), pcm_data_out, vecs[v].exp);
            @(negedge clk);
            chk_i($sformatf("v%0d_valid_width", v), int'(pcm_valid), 0);
            wait_valid(at);
            chk_i($sformatf("v%0d_second_latency", v), at, FIRST_VALID + FRAME);
            chk($sformatf("v%0d_second_data", v), pcm_data_out, vecs[v].exp);
        end

        // en dropped for one cycle during the last COMB cycle of frame 5
        restart('1, '0);
        wait_valid(at);
        chk_i("endrop_pre_latency", at, FIRST_VALID);
        for (int i = 0; i < 2000 && cyc != FIRST_VALID + FRAME - 1; i++) @(negedge clk);
        chk_i("endrop_reached", cyc, FIRST_VALID + FRAME - 1);
        en = 1'b0;
        #1;
        chk_i("endrop_pdm_clk", int'(pdm_clk), 0);
        chk_i("endrop_valid", int'(pcm_valid), 0);
        chk("endrop_data_held", pcm_data_out, ALL_7F);
        @(negedge clk);
        en        = 1'b1;
        ones_mask = '0;
        held_ok   = 1;
        at        = -1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (pcm_valid) begin
                at = cyc;
                break;
            end
            if (pcm_data_out !== ALL_7F) held_ok = 0;
        end
        chk_i("endrop_hold_until_publish", held_ok, 1);
        chk_i("endrop_restart_latency", at, FIRST_VALID);
        chk("endrop_restart_data", pcm_data_out, ALL_80);

        // Asynchronous reset mid-frame
        restart('1, '0);
        wait_valid(at);
        chk_i("rst_pre_latency", at, FIRST_VALID);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_i("rst_pdm_clk", int'(pdm_clk), 0);
        chk_i("rst_valid", int'(pcm_valid), 0);
        chk("rst_data", pcm_data_out, '0);
        repeat (3) @(negedge clk);
        chk("rst_data_hold", pcm_data_out, '0);
        chk_i("rst_valid_hold", int'(pcm_valid), 0);
        rst_n = 1'b1;
        wait_valid(at);
        chk_i("rst_restart_latency", at, FIRST_VALID);
        chk("rst_restart_data", pcm_data_out, ALL_7F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
